// File: rtl/rrf_commit_ctrl_pkg.sv
// Shared types and sizing for the RRF retirement controller.
// No logic; widths, FSM encodings and the ROB-head commit record.
// Backpressure: n/a.
package rrf_commit_ctrl_pkg;

  localparam int PHYS_BITS      = 6;
  localparam int ARCH_BITS      = 5;
  localparam int ARCH_COUNT     = 1 << ARCH_BITS;
  localparam int NSIZE          = 2;
  localparam int RESTORE_LANES  = 8;
  localparam int RESTORE_CHUNKS = ARCH_COUNT / RESTORE_LANES;
  localparam int CNT_BITS       = (RESTORE_CHUNKS > 1) ? $clog2(RESTORE_CHUNKS) : 1;
  localparam int FL_BITS        = $clog2(NSIZE + 1);

  typedef logic [ARCH_BITS-1:0] arch_t;
  typedef logic [PHYS_BITS-1:0] phys_t;

  typedef logic [1:0] state_t;
  localparam state_t ST_RUN     = 2'd0;
  localparam state_t ST_FLUSH   = 2'd1;
  localparam state_t ST_RESTORE = 2'd2;

  typedef struct packed {
    logic  valid;
    logic  ready;
    logic  we;
    logic  mispredict;
    arch_t rd;
    phys_t pd;
  } rob_head_t;

  // x0 is hardwired, so a write to it never displaces a physical register.
  function automatic logic head_frees(rob_head_t h);
    return h.we && (h.rd != '0);
  endfunction

endpackage

// File: rtl/rrf_commit_ctrl_if.sv
// ROB head / RRF / free-list / RAT-restore bundle around the commit controller.
// No logic; master is the controller side.
// Backpressure: free-list space is the only throttle on retirement.
interface rrf_commit_ctrl_if import rrf_commit_ctrl_pkg::*; ();

  logic [NSIZE-1:0]   rob_head_valid;
  logic [NSIZE-1:0]   rob_head_ready;
  logic [NSIZE-1:0]   rob_head_we;
  logic [NSIZE-1:0]   rob_head_mispredict;
  arch_t              rob_head_rd [NSIZE];
  phys_t              rob_head_pd [NSIZE];
  logic [NSIZE-1:0]   rob_dequeue;

  arch_t              alias_rd [NSIZE];
  phys_t              alias_pd [NSIZE];
  logic [NSIZE-1:0]   alias_regf_we;
  phys_t              alias_pd_old [NSIZE];
  phys_t              alias_mem [ARCH_COUNT];

  logic [NSIZE-1:0]   fl_push;
  phys_t              fl_push_pd [NSIZE];
  logic [FL_BITS-1:0] fl_space;

  logic               flush;
  logic               rat_restore_we;
  arch_t              rat_restore_base;
  phys_t              rat_restore_pd [RESTORE_LANES];
  logic               stall_rename;

  modport master (
    input  rob_head_valid, rob_head_ready, rob_head_we, rob_head_mispredict,
    input  rob_head_rd, rob_head_pd, alias_pd_old, alias_mem, fl_space,
    output rob_dequeue, alias_rd, alias_pd, alias_regf_we, fl_push, fl_push_pd,
    output flush, rat_restore_we, rat_restore_base, rat_restore_pd, stall_rename
  );

  modport slave (
    output rob_head_valid, rob_head_ready, rob_head_we, rob_head_mispredict,
    output rob_head_rd, rob_head_pd, alias_pd_old, alias_mem, fl_space,
    input  rob_dequeue, alias_rd, alias_pd, alias_regf_we, fl_push, fl_push_pd,
    input  flush, rat_restore_we, rat_restore_base, rat_restore_pd, stall_rename
  );

endinterface

// File: rtl/rrf_commit_ctrl_restore_seq.sv
// Chunked RRF -> speculative RAT copy, RESTORE_LANES entries per cycle.
// Starts the cycle after start; done flags the last chunk, RESTORE_CHUNKS cycles later.
// Backpressure: none; the copy always runs to completion unless reset.
module rrf_restore_seq import rrf_commit_ctrl_pkg::*; (
  input  logic  clk,
  input  logic  rst,
  input  logic  start,
  input  phys_t alias_mem [ARCH_COUNT],
  output logic  done,
  output logic  restore_we,
  output arch_t restore_base,
  output phys_t restore_pd [RESTORE_LANES]
);

  logic                busy;
  logic                active;
  logic                last;
  logic [CNT_BITS-1:0] cnt;

  assign last   = (cnt == CNT_BITS'(RESTORE_CHUNKS - 1));
  assign active = busy && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
    end else if (busy) begin
      if (last) begin
        busy <= 1'b0;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign done         = active && last;
  assign restore_we   = active;
  assign restore_base = active ? ARCH_BITS'(cnt) * ARCH_BITS'(RESTORE_LANES) : '0;

  for (genvar k = 0; k < RESTORE_LANES; k++) begin : g_chunk
    assign restore_pd[k] = active ? alias_mem[restore_base + ARCH_BITS'(k)] : '0;
  end

endmodule

// File: rtl/rrf_commit_ctrl.sv
// In-order retirement of up to NSIZE ROB heads into the RRF, with mispredict squash + RAT restore.
// Commit is combinational (same cycle); flush at C+1, restore C+2..C+1+RESTORE_CHUNKS.
// Backpressure: retirement stops at the first lane whose free-list return would exceed fl_space.
module rrf_commit_ctrl import rrf_commit_ctrl_pkg::*; (
  input  logic               clk,
  input  logic               rst,
  rrf_commit_ctrl_if.master  rif
);

  state_t             state;
  state_t             state_nxt;
  rob_head_t          head [NSIZE];
  logic [NSIZE-1:0]   retire;
  logic [NSIZE-1:0]   frees;
  logic               mis_retire;
  logic               open;
  logic [FL_BITS-1:0] used;
  logic [FL_BITS-1:0] used_nxt;
  logic               restore_done;

  for (genvar i = 0; i < NSIZE; i++) begin : g_head
    assign head[i] = '{valid:      rif.rob_head_valid[i],
                       ready:      rif.rob_head_ready[i],
                       we:         rif.rob_head_we[i],
                       mispredict: rif.rob_head_mispredict[i],
                       rd:         rif.rob_head_rd[i],
                       pd:         rif.rob_head_pd[i]};
  end

  // Lanes retire as a contiguous prefix; a retiring mispredict closes the window behind it.
  always_comb begin
    retire     = '0;
    frees      = '0;
    mis_retire = 1'b0;
    used       = '0;
    used_nxt   = '0;
    open       = (state == ST_RUN) && !rst;
    for (int i = 0; i < NSIZE; i++) begin
      used_nxt = used + FL_BITS'(head_frees(head[i]));
      if (open && head[i].valid && head[i].ready && (used_nxt <= rif.fl_space)) begin
        retire[i] = 1'b1;
        frees[i]  = head_frees(head[i]);
        used      = used_nxt;
        if (head[i].mispredict) begin
          mis_retire = 1'b1;
          open       = 1'b0;
        end
      end else begin
        open = 1'b0;
      end
    end
  end

  assign rif.rob_dequeue   = retire;
  assign rif.alias_regf_we = frees;
  assign rif.fl_push       = frees;

  for (genvar i = 0; i < NSIZE; i++) begin : g_lane
    assign rif.alias_rd[i]   = frees[i] ? head[i].rd : '0;
    assign rif.alias_pd[i]   = frees[i] ? head[i].pd : '0;
    assign rif.fl_push_pd[i] = frees[i] ? rif.alias_pd_old[i] : '0;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:     if (mis_retire) state_nxt = ST_FLUSH;
      ST_FLUSH:   state_nxt = ST_RESTORE;
      ST_RESTORE: if (restore_done) state_nxt = ST_RUN;
      default:    state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_RUN;
    else     state <= state_nxt;
  end

  assign rif.flush        = !rst && (state == ST_FLUSH);
  assign rif.stall_rename = !rst && ((state == ST_FLUSH) || (state == ST_RESTORE));

  rrf_restore_seq u_restore_seq (
    .clk          (clk),
    .rst          (rst),
    .start        (rif.flush),
    .alias_mem    (rif.alias_mem),
    .done         (restore_done),
    .restore_we   (rif.rat_restore_we),
    .restore_base (rif.rat_restore_base),
    .restore_pd   (rif.rat_restore_pd)
  );

endmodule

// File: tb/tb_rrf_commit_ctrl.sv
// Randomized bench for rrf_commit_ctrl against a phase-counting reference model.
// Includes an RRF with same-cycle forwarding; directed test-plan cases run first.
module tb_rrf_commit_ctrl;
  import rrf_commit_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic env_init = 1'b1;
  always #5 clk = ~clk;

  rrf_commit_ctrl_if rif ();

  rrf_commit_ctrl dut (.clk(clk), .rst(rst), .rif(rif));

  int n_checks = 0;
  int n_errs   = 0;

  // RRF model: identity at start, written by the DUT's alias lanes.
  phys_t env_rrf [ARCH_COUNT];

  always @(posedge clk) begin
    if (env_init) begin
      for (int a = 0; a < ARCH_COUNT; a++) env_rrf[a] <= phys_t'(a);
    end else begin
      for (int i = 0; i < NSIZE; i++)
        if (rif.alias_regf_we[i]) env_rrf[rif.alias_rd[i]] <= rif.alias_pd[i];
    end
  end

  always_comb begin
    for (int a = 0; a < ARCH_COUNT; a++) rif.alias_mem[a] = env_rrf[a];
    rif.alias_pd_old[0] = env_rrf[rif.rob_head_rd[0]];
    rif.alias_pd_old[1] = (rif.rob_head_we[0] && rif.rob_head_rd[0] != '0 &&
                           rif.rob_head_rd[0] == rif.rob_head_rd[1])
                          ? rif.rob_head_pd[0] : env_rrf[rif.rob_head_rd[1]];
  end

  // Reference model state: phase 0 = running, 1 = flush, 2.. = restore chunk phase-2.
  phys_t            m_rrf [ARCH_COUNT];
  int               m_phase;
  logic [NSIZE-1:0] e_deq, e_fre;
  logic             e_mis, e_flush, e_stall, e_rwe;
  arch_t            e_rd [NSIZE];
  phys_t            e_pd [NSIZE];
  phys_t            e_old [NSIZE];
  arch_t            e_base;
  phys_t            e_rpd [RESTORE_LANES];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_eval(input bit r);
    phys_t tmp [ARCH_COUNT];
    int    budget;
    bit    blocked;
    bit    fr;
    e_deq = '0;
    e_fre = '0;
    e_mis = 1'b0;
    for (int i = 0; i < NSIZE; i++) begin
      e_rd[i]  = '0;
      e_pd[i]  = '0;
      e_old[i] = '0;
    end
    e_flush = !r && (m_phase == 1);
    e_stall = !r && (m_phase != 0);
    e_rwe   = !r && (m_phase >= 2);
    e_base  = e_rwe ? ARCH_BITS'((m_phase - 2) * RESTORE_LANES) : '0;
    for (int k = 0; k < RESTORE_LANES; k++)
      e_rpd[k] = e_rwe ? m_rrf[int'(e_base) + k] : '0;
    if (r || m_phase != 0) return;
    tmp     = m_rrf;
    budget  = int'(rif.fl_space);
    blocked = 1'b0;
    for (int i = 0; i < NSIZE; i++) begin
      if (!blocked) begin
        fr = rif.rob_head_we[i] && (rif.rob_head_rd[i] != '0);
        if (!(rif.rob_head_valid[i] && rif.rob_head_ready[i]) || (fr && budget == 0)) begin
          blocked = 1'b1;
        end else begin
          e_deq[i] = 1'b1;
          if (fr) begin
            budget--;
            e_fre[i] = 1'b1;
            e_rd[i]  = rif.rob_head_rd[i];
            e_pd[i]  = rif.rob_head_pd[i];
            e_old[i] = tmp[rif.rob_head_rd[i]];
            tmp[rif.rob_head_rd[i]] = rif.rob_head_pd[i];
          end
          if (rif.rob_head_mispredict[i]) begin
            e_mis   = 1'b1;
            blocked = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic model_advance(input bit r);
    if (r) begin
      m_phase = 0;
    end else if (m_phase == 0) begin
      for (int i = 0; i < NSIZE; i++)
        if (e_fre[i]) m_rrf[e_rd[i]] = e_pd[i];
      if (e_mis) m_phase = 1;
    end else if (m_phase == RESTORE_CHUNKS + 1) begin
      m_phase = 0;
    end else begin
      m_phase++;
    end
  endtask

  task automatic check_all();
    chk("rob_dequeue", 64'(rif.rob_dequeue), 64'(e_deq));
    chk("alias_regf_we", 64'(rif.alias_regf_we), 64'(e_fre));
    chk("fl_push", 64'(rif.fl_push), 64'(e_fre));
    for (int i = 0; i < NSIZE; i++) begin
      chk($sformatf("alias_rd[%0d]", i), 64'(rif.alias_rd[i]), 64'(e_rd[i]));
      chk($sformatf("alias_pd[%0d]", i), 64'(rif.alias_pd[i]), 64'(e_pd[i]));
      chk($sformatf("fl_push_pd[%0d]", i), 64'(rif.fl_push_pd[i]), 64'(e_old[i]));
    end
    chk("flush", 64'(rif.flush), 64'(e_flush));
    chk("stall_rename", 64'(rif.stall_rename), 64'(e_stall));
    chk("rat_restore_we", 64'(rif.rat_restore_we), 64'(e_rwe));
    chk("rat_restore_base", 64'(rif.rat_restore_base), 64'(e_base));
    for (int k = 0; k < RESTORE_LANES; k++)
      chk($sformatf("rat_restore_pd[%0d]", k), 64'(rif.rat_restore_pd[k]), 64'(e_rpd[k]));
  endtask

  // One clock: drive after the edge, compare at the falling edge, then step the model.
  task automatic cycle(input bit r, input logic [1:0] v, input logic [1:0] rdy,
                       input logic [1:0] we, input logic [1:0] mis,
                       input int rd0, input int pd0, input int rd1, input int pd1,
                       input int fs);
    @(posedge clk);
    #1;
    rst                     = r;
    rif.rob_head_valid      = v;
    rif.rob_head_ready      = rdy;
    rif.rob_head_we         = we;
    rif.rob_head_mispredict = mis;
    rif.rob_head_rd[0]      = arch_t'(rd0);
    rif.rob_head_pd[0]      = phys_t'(pd0);
    rif.rob_head_rd[1]      = arch_t'(rd1);
    rif.rob_head_pd[1]      = phys_t'(pd1);
    rif.fl_space            = FL_BITS'(fs);
    #4;
    model_eval(r);
    check_all();
    model_advance(r);
  endtask

  task automatic idle(input bit r);
    cycle(r, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 2);
  endtask

  initial begin
    for (int a = 0; a < ARCH_COUNT; a++) m_rrf[a] = phys_t'(a);
    m_phase = 0;
    rif.rob_head_valid      = '0;
    rif.rob_head_ready      = '0;
    rif.rob_head_we         = '0;
    rif.rob_head_mispredict = '0;
    for (int i = 0; i < NSIZE; i++) begin
      rif.rob_head_rd[i] = '0;
      rif.rob_head_pd[i] = '0;
    end
    rif.fl_space = '0;

    idle(1'b1);
    env_init = 1'b0;
    idle(1'b1);
    idle(1'b0);

    // Two freeing lanes, old maps come from the identity RRF.
    cycle(1'b0, 2'b11, 2'b11, 2'b11, 2'b00, 3, 40, 4, 41, 2);
    chk("tp1_deq", 64'(rif.rob_dequeue), 64'(2'b11));
    chk("tp1_push0", 64'(rif.fl_push_pd[0]), 64'd3);
    chk("tp1_push1", 64'(rif.fl_push_pd[1]), 64'd4);

    // Same rd on both lanes: lane1 frees lane0's new mapping.
    cycle(1'b0, 2'b11, 2'b11, 2'b11, 2'b00, 5, 42, 5, 43, 2);
    chk("tp2_push0", 64'(rif.fl_push_pd[0]), 64'd5);
    chk("tp2_push1", 64'(rif.fl_push_pd[1]), 64'd42);
    idle(1'b0);
    chk("tp2_x5", 64'(env_rrf[5]), 64'd43);

    // Head not ready blocks everything behind it.
    cycle(1'b0, 2'b11, 2'b10, 2'b11, 2'b00, 6, 44, 9, 45, 2);
    chk("tp3_deq", 64'(rif.rob_dequeue), 64'(2'b00));

    // One free slot: only lane0; then the former lane1 retires.
    cycle(1'b0, 2'b11, 2'b11, 2'b11, 2'b00, 10, 46, 11, 47, 1);
    chk("tp4_deq_a", 64'(rif.rob_dequeue), 64'(2'b01));
    cycle(1'b0, 2'b01, 2'b01, 2'b01, 2'b00, 11, 47, 0, 0, 1);
    chk("tp4_deq_b", 64'(rif.rob_dequeue), 64'(2'b01));

    // No space, but x0 and no-write heads still retire.
    cycle(1'b0, 2'b11, 2'b11, 2'b01, 2'b00, 0, 48, 12, 49, 0);
    chk("tp_nofree_deq", 64'(rif.rob_dequeue), 64'(2'b11));

    // Mispredict in lane0 blocks lane1, then flush and four restore chunks.
    cycle(1'b0, 2'b11, 2'b11, 2'b11, 2'b01, 7, 50, 8, 51, 2);
    chk("tp5_deq", 64'(rif.rob_dequeue), 64'(2'b01));
    cycle(1'b0, 2'b11, 2'b11, 2'b11, 2'b00, 8, 51, 9, 52, 2);
    chk("tp5_flush", 64'(rif.flush), 64'd1);
    chk("tp5_flush_deq", 64'(rif.rob_dequeue), 64'(2'b00));
    idle(1'b0);
    chk("tp5_base0", 64'(rif.rat_restore_base), 64'd0);
    chk("tp5_pd7", 64'(rif.rat_restore_pd[7]), 64'd50);
    for (int j = 0; j < RESTORE_CHUNKS - 1; j++) idle(1'b0);
    idle(1'b0);
    chk("tp5_stall_drop", 64'(rif.stall_rename), 64'd0);

    // Reset during the base-8 chunk aborts the copy.
    cycle(1'b0, 2'b01, 2'b01, 2'b01, 2'b01, 13, 53, 0, 0, 2);
    idle(1'b0);
    idle(1'b0);
    chk("tp6_base0", 64'(rif.rat_restore_base), 64'd0);
    idle(1'b1);
    idle(1'b0);
    chk("tp6_run_we", 64'(rif.rat_restore_we), 64'd0);
    chk("tp6_run_stall", 64'(rif.stall_rename), 64'd0);

    for (int n = 0; n < 3000; n++) begin
      logic [1:0] mis;
      mis[0] = ($urandom_range(0, 11) == 0);
      mis[1] = ($urandom_range(0, 11) == 0);
      cycle(($urandom_range(0, 199) == 0),
            2'($urandom), ($urandom_range(0, 3) != 0) ? 2'b11 : 2'($urandom),
            2'($urandom), mis,
            $urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31),
            $urandom_range(0, 63),
            $urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31),
            $urandom_range(0, 63),
            $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/rrf_commit_ctrl.md
# rrf_commit_ctrl

In-order retirement controller between the ROB head and the retirement register file (RRF). Each cycle it picks up to NSIZE ready ROB head entries, drives the RRF write lanes, and returns each displaced physical register to the free list. On a retiring mispredict it squashes the machine and copies the RRF image into the speculative RAT over several cycles.

## Interface
- PHYS_BITS, 6, physical register index width
- ARCH_BITS, 5, architectural register index width; ARCH_COUNT = 2**ARCH_BITS
- NSIZE, 2, commit lanes per cycle
- RESTORE_LANES, 8, RAT entries restored per cycle; must divide ARCH_COUNT
- clk  in  1  clock; single clock domain
- rst  in  1  synchronous, active-high reset
- rob_head_valid / rob_head_ready / rob_head_we / rob_head_mispredict  in  1 [NSIZE]  head entry i (i=0 oldest): present, result done, writes rd, redirects
- rob_head_rd  in  ARCH_BITS [NSIZE]  destination arch reg
- rob_head_pd  in  PHYS_BITS [NSIZE]  destination phys reg
- rob_dequeue  out  1 [NSIZE]  entry i retires this cycle
- alias_rd / alias_pd / alias_regf_we  out  ARCH_BITS / PHYS_BITS / 1 [NSIZE]  RRF write lanes
- alias_pd_old  in  PHYS_BITS [NSIZE]  RRF's previous mapping per lane (same-cycle forwarded)
- alias_mem  in  PHYS_BITS [ARCH_COUNT]  current RRF image
- fl_push  out  1 [NSIZE]; fl_push_pd  out  PHYS_BITS [NSIZE]  free-list returns
- fl_space  in  $clog2(NSIZE+1)  free-list slots available this cycle
- flush  out  1  squash pulse to ROB, reservation stations, rename
- rat_restore_we  out  1; rat_restore_base  out  ARCH_BITS; rat_restore_pd  out  PHYS_BITS [RESTORE_LANES]
- stall_rename  out  1  hold rename/dispatch

## Operation
- FSM states RUN, FLUSH, RESTORE; reset → RUN, restore counter 0.
- RUN, lane i retires iff: lane i−1 retired (lane 0: true); valid & ready; no mispredict retired in a lower lane; cumulative free count through lane i ≤ fl_space.
- Lane frees iff retiring & we & rd≠0. alias_regf_we = frees; alias_rd/pd = head rd/pd; fl_push = frees; fl_push_pd = alias_pd_old.
- we with rd=0: retires, no RRF write, no free-list push.
- Mispredict entry retires (incl. its RRF write/free); lanes above blocked; next state FLUSH.
- FLUSH: one cycle; flush=1, rob_dequeue all 0, RRF lanes idle.
- RESTORE: ARCH_COUNT/RESTORE_LANES cycles; rat_restore_we=1, base = cnt·RESTORE_LANES, pd[k] = alias_mem[base+k]; counter increments; last chunk → RUN, counter cleared.
- stall_rename = 1 in FLUSH and RESTORE.

## Timing
- Reset values: every output 0, state RUN.
- Commit decision combinational from ROB head/fl_space to rob_dequeue, alias_*, fl_push in the same cycle; RRF updates at that edge.
- Mispredict retire cycle C: flush at C+1; restore at C+2 … C+1+ARCH_COUNT/RESTORE_LANES; RUN resumes next cycle (default 4 restore cycles, RUN at C+6).
- RESTORE reads post-commit RRF (mispredict write landed at C edge).
- ROB inputs ignored outside RUN.
- rst in FLUSH/RESTORE aborts immediately → RUN, counter 0, no further restore writes.
- fl_space=0 with freeing head: no retirement; non-freeing heads (we=0 or rd=0) still retire.

## Structure
- Shared package: state enum (RUN/FLUSH/RESTORE), ARCH/PHYS width constants, ROB-head commit struct.
- One sub-module natural: rrf_restore_seq (counter + chunked RAT write driver), started by FSM on FLUSH exit, done back to FSM.
- RRF_n instantiated by the parent, not inside this block.

## Test plan
- Both lanes ready, we=1, rd=3/pd=40 and rd=4/pd=41, fl_space=2 → rob_dequeue=11, alias_regf_we=11, fl_push_pd = old map of x3/x4 (3,4 after reset).
- Lane0 ready rd=5 pd=42, lane1 ready rd=5 pd=43 → lane1 fl_push_pd=42 (forwarded), RRF x5=43 next cycle.
- Lane0 not ready, lane1 ready → rob_dequeue=00, no pushes.
- fl_space=1, both lanes free-producing → only lane0 retires; lane1 retires next cycle with fl_space=1.
- Lane0 mispredict rd=7 pd=50, lane1 ready → lane1 blocked; flush one cycle; 4 restore cycles bases 0,8,16,24, base-0 chunk pd[7]=50; RUN resumes, stall_rename drops.
- rst asserted mid-RESTORE (base 8) → next cycle RUN, all outputs 0, no base-16 write.
